wf_slot_alloc: RTL and testbench



---
 rtl/fetch_wf_pkg.sv | 13 +
 rtl/wf_onehot_dec.sv | 20 ++
 rtl/wf_slot_alloc.sv | 127 ++++++++++++
 tb/tb_wf_slot_alloc.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_wf_pkg.sv
// Shared definitions for the fetch-stage wavefront slot logic: default sizing,
// allocation policy codes and the wfid type.
package fetch_wf_pkg;

    localparam int NUM_WF_DEFAULT = 40;
    localparam int WFID_W_DEFAULT = 6;

    localparam int ALLOC_LOWEST = 0;
    localparam int ALLOC_RR     = 1;

    typedef logic [WFID_W_DEFAULT-1:0] wfid_t;

endpackage

// File: rtl/wf_onehot_dec.sv
// Binary wfid to one-hot decoder; an index outside 0..NUM_WF-1 decodes to all zeros.
module wf_onehot_dec
    import fetch_wf_pkg::*;
#(
    parameter int NUM_WF = NUM_WF_DEFAULT,
    parameter int WFID_W = WFID_W_DEFAULT
) (
    input  logic [WFID_W-1:0] wfid,
    output logic [NUM_WF-1:0] onehot
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        onehot = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            if (wfid == WFID_W'(i)) onehot[i] = 1'b1;
        end
    end

endmodule

// File: rtl/wf_slot_alloc.sv
// Stateful wavefront-slot allocator: busy bitmap, one grant per cycle
// (lowest-free or round-robin), decoded releases with illegal-release flagging.
module wf_slot_alloc
    import fetch_wf_pkg::*;
#(
    parameter int NUM_WF     = NUM_WF_DEFAULT,
    parameter int WFID_W     = WFID_W_DEFAULT,
    parameter int ALLOC_MODE = ALLOC_LOWEST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_req,
    input  logic              release_valid,
    input  logic [WFID_W-1:0] release_wfid,
    output logic              alloc_valid,
    output logic              alloc_nack,
    output logic [WFID_W-1:0] alloc_wfid,
    output logic [NUM_WF-1:0] alloc_onehot,
    output logic [NUM_WF-1:0] busy_mask,
    output logic [WFID_W:0]   free_count,
    output logic              full,
    output logic              empty,
    output logic              release_err
);

    if (NUM_WF < 2 || NUM_WF > 64 || (2 ** WFID_W) < NUM_WF ||
        (ALLOC_MODE != ALLOC_LOWEST && ALLOC_MODE != ALLOC_RR)) begin : g_param_check
        $error("wf_slot_alloc: illegal NUM_WF/WFID_W/ALLOC_MODE combination");
    end

    localparam logic [WFID_W:0] CNT_ONE = (WFID_W+1)'(1);
    localparam logic [WFID_W:0] CNT_ALL = (WFID_W+1)'(NUM_WF);

    logic [NUM_WF-1:0] busy_q, busy_d, free_mask, sel_onehot, rel_onehot;
    logic [WFID_W:0]   free_q, free_d;
    logic [WFID_W-1:0] sel_wfid;
    logic              grant, rel_legal, rel_bad;

    function automatic logic [WFID_W-1:0] lowest_set(input logic [NUM_WF-1:0] vec);
        lowest_set = '0;
        for (int i = NUM_WF - 1; i >= 0; i--) begin
            if (vec[i]) lowest_set = WFID_W'(i);
        end
    endfunction

    // Decisions use the registered state only, so a same-cycle release can never feed a grant.
    assign free_mask = ~busy_q;
    assign grant     = alloc_req && !full;

    wf_onehot_dec #(.NUM_WF(NUM_WF), .WFID_W(WFID_W)) u_sel_dec (
        .wfid   (sel_wfid),
        .onehot (sel_onehot)
    );

    wf_onehot_dec #(.NUM_WF(NUM_WF), .WFID_W(WFID_W)) u_rel_dec (
        .wfid   (release_wfid),
        .onehot (rel_onehot)
    );

    // An out-of-range wfid decodes to zero, so it can never hit a busy bit.
    assign rel_legal = release_valid && (|(rel_onehot & busy_q));
    assign rel_bad   = release_valid && !rel_legal;

    always_comb begin
        busy_d = busy_q;
        free_d = free_q;
        if (rel_legal) begin
            busy_d = busy_d & ~rel_onehot;
            free_d = free_d + CNT_ONE;
        end
        if (grant) begin
            busy_d = busy_d | sel_onehot;
            free_d = free_d - CNT_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= '0;
            free_q       <= CNT_ALL;
            full         <= 1'b0;
            empty        <= 1'b1;
            alloc_valid  <= 1'b0;
            alloc_nack   <= 1'b0;
            alloc_wfid   <= '0;
            alloc_onehot <= '0;
            release_err  <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            free_q       <= free_d;
            full         <= (free_d == '0);
            empty        <= (free_d == CNT_ALL);
            alloc_valid  <= grant;
            alloc_nack   <= alloc_req && full;
            alloc_wfid   <= grant ? sel_wfid : '0;
            alloc_onehot <= grant ? sel_onehot : '0;
            release_err  <= rel_bad;
        end
    end

    assign busy_mask  = busy_q;
    assign free_count = free_q;

    if (ALLOC_MODE == ALLOC_RR) begin : g_rr
        logic [WFID_W-1:0] rr_ptr_q, rot_idx;
        logic [NUM_WF-1:0] rot_free;
        logic [WFID_W:0]   rr_sum;

        // Rotate the free mask so rr_ptr lands at bit 0, then map the hit back modulo NUM_WF.
        assign rot_free = NUM_WF'({free_mask, free_mask} >> rr_ptr_q);
        assign rot_idx  = lowest_set(rot_free);
        assign rr_sum   = {1'b0, rot_idx} + {1'b0, rr_ptr_q};
        assign sel_wfid = (rr_sum >= CNT_ALL) ? WFID_W'(rr_sum - CNT_ALL) : rr_sum[WFID_W-1:0];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rr_ptr_q <= '0;
            end else if (grant) begin
                rr_ptr_q <= (sel_wfid == WFID_W'(NUM_WF - 1)) ? '0 : sel_wfid + 1'b1;
            end
        end
    end else begin : g_lowest
        assign sel_wfid = lowest_set(free_mask);
    end

endmodule

// File: tb/tb_wf_slot_alloc.sv
// Self-checking bench for wf_slot_alloc: five parameter sets run side by side,
// each compared every cycle against a slot-pool reference model.
module tb_wf_slot_alloc;
    import fetch_wf_pkg::*;

    localparam int NCFG = 5;
    localparam int CFG_N [NCFG] = '{40, 40, 8, 64, 6};
    localparam int CFG_W [NCFG] = '{6, 6, 3, 6, 3};
    localparam int CFG_M [NCFG] = '{ALLOC_LOWEST, ALLOC_RR, ALLOC_RR, ALLOC_RR, ALLOC_LOWEST};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req    [NCFG];
    logic        rel_v  [NCFG];
    logic [5:0]  rel_id [NCFG];

    logic        o_valid [NCFG];
    logic        o_nack  [NCFG];
    logic        o_full  [NCFG];
    logic        o_empty [NCFG];
    logic        o_err   [NCFG];
    logic [5:0]  o_wfid  [NCFG];
    logic [63:0] o_oh    [NCFG];
    logic [63:0] o_busy  [NCFG];
    logic [6:0]  o_free  [NCFG];

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int N = CFG_N[g];
        localparam int W = CFG_W[g];
        logic [W-1:0] rid, wid;
        logic [N-1:0] oh, bm;
        logic [W:0]   fc;

        assign rid = rel_id[g][W-1:0];

        wf_slot_alloc #(.NUM_WF(N), .WFID_W(W), .ALLOC_MODE(CFG_M[g])) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .alloc_req     (req[g]),
            .release_valid (rel_v[g]),
            .release_wfid  (rid),
            .alloc_valid   (o_valid[g]),
            .alloc_nack    (o_nack[g]),
            .alloc_wfid    (wid),
            .alloc_onehot  (oh),
            .busy_mask     (bm),
            .free_count    (fc),
            .full          (o_full[g]),
            .empty         (o_empty[g]),
            .release_err   (o_err[g])
        );

        assign o_wfid[g] = 6'(wid);
        assign o_oh[g]   = 64'(oh);
        assign o_busy[g] = 64'(bm);
        assign o_free[g] = 7'(fc);
    end

    int checks   = 0;
    int failures = 0;

    // Reference model: a set of busy slot numbers plus the round-robin start point.
    bit mbusy   [NCFG][64];
    int mrr     [NCFG];
    bit e_valid [NCFG];
    bit e_nack  [NCFG];
    bit e_err   [NCFG];
    int e_wfid  [NCFG];

    task automatic check(input string tag, input int c, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cfg%0d: observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    function automatic int nbusy(input int c);
        int n = 0;
        for (int i = 0; i < CFG_N[c]; i++) n += int'(mbusy[c][i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCFG; c++) begin
            for (int i = 0; i < 64; i++) mbusy[c][i] = 1'b0;
            mrr[c]     = 0;
            e_valid[c] = 1'b0;
            e_nack[c]  = 1'b0;
            e_err[c]   = 1'b0;
            e_wfid[c]  = 0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NCFG; c++) begin
            int n = CFG_N[c];
            int g = -1;
            int w = int'(rel_id[c]);
            bit legal;
            e_valid[c] = 1'b0;
            e_nack[c]  = 1'b0;
            if (req[c] === 1'b1) begin
                if (nbusy(c) == n) begin
                    e_nack[c] = 1'b1;
                end else begin
                    for (int k = 0; k < n; k++) begin
                        int idx;
                        idx = (CFG_M[c] == ALLOC_RR) ? (mrr[c] + k) % n : k;
                        if (g < 0 && !mbusy[c][idx]) g = idx;
                    end
                end
            end
            legal    = (rel_v[c] === 1'b1) && (w < n) && mbusy[c][w];
            e_err[c] = (rel_v[c] === 1'b1) && !legal;
            if (legal) mbusy[c][w] = 1'b0;
            if (g >= 0) begin
                mbusy[c][g] = 1'b1;
                mrr[c]      = (g + 1) % n;
                e_valid[c]  = 1'b1;
                e_wfid[c]   = g;
            end
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < NCFG; c++) begin
            logic [63:0] eb;
            int nb;
            eb = '0;
            nb = nbusy(c);
            for (int i = 0; i < CFG_N[c]; i++) eb[i] = mbusy[c][i];
            check("alloc_valid", c, 64'(o_valid[c]), 64'(e_valid[c]));
            check("alloc_nack", c, 64'(o_nack[c]), 64'(e_nack[c]));
            check("release_err", c, 64'(o_err[c]), 64'(e_err[c]));
            if (e_valid[c]) begin
                check("alloc_wfid", c, 64'(o_wfid[c]), 64'(e_wfid[c]));
                check("alloc_onehot", c, o_oh[c], 64'(1) << e_wfid[c]);
            end else begin
                check("alloc_onehot_idle", c, o_oh[c], 64'(0));
            end
            check("busy_mask", c, o_busy[c], eb);
            check("free_count", c, 64'(o_free[c]), 64'(CFG_N[c] - nb));
            check("full", c, 64'(o_full[c]), 64'(nb == CFG_N[c]));
            check("empty", c, 64'(o_empty[c]), 64'(nb == 0));
        end
    endtask

    task automatic idle();
        for (int c = 0; c < NCFG; c++) begin
            req[c]    = 1'b0;
            rel_v[c]  = 1'b0;
            rel_id[c] = '0;
        end
    endtask

    task automatic all_req();
        for (int c = 0; c < NCFG; c++) req[c] = 1'b1;
    endtask

    task automatic set_rel(input int c, input int id);
        rel_v[c]  = 1'b1;
        rel_id[c] = 6'(id % (1 << CFG_W[c]));
    endtask

    // Inputs change 1 time unit after the edge; outputs are compared at the same point.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        #12;
        check_all();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill every pool; the smaller ones keep requesting and must nack.
        repeat (64) begin
            all_req();
            step();
        end
        check("fill_full", 0, 64'(o_full[0]), 64'(1));
        check("fill_free", 0, 64'(o_free[0]), 64'(0));

        // Full pool with a release in the same cycle still nacks.
        all_req();
        set_rel(0, 17);
        set_rel(1, 17);
        step();
        check("full_rel_nack", 0, 64'(o_nack[0]), 64'(1));
        check("full_rel_bit17", 0, 64'(o_busy[0][17]), 64'(0));
        check("full_rel_free", 0, 64'(o_free[0]), 64'(1));
        all_req();
        step();
        check("regrant_17", 0, 64'(o_wfid[0]), 64'(17));
        check("regrant_17_rr", 1, 64'(o_wfid[1]), 64'(17));

        // Illegal releases: out of range, then a slot that is already free.
        set_rel(0, 45);
        set_rel(1, 45);
        set_rel(4, 7);
        step();
        check("rel_oob", 0, 64'(o_err[0]), 64'(1));
        check("rel_oob_small", 4, 64'(o_err[4]), 64'(1));
        set_rel(0, 5);
        step();
        set_rel(0, 5);
        step();
        check("rel_already_free", 0, 64'(o_err[0]), 64'(1));

        // Drain by walking every encodable wfid.
        for (int i = 0; i < 64; i++) begin
            for (int c = 0; c < NCFG; c++) set_rel(c, i);
            step();
        end
        check("drained_empty", 0, 64'(o_empty[0]), 64'(1));
        check("drained_empty64", 3, 64'(o_empty[3]), 64'(1));

        // Asynchronous reset mid-stream with slots busy and a request pending.
        repeat (10) begin
            all_req();
            step();
        end
        all_req();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        all_req();
        rst_n = 1'b1;
        step();
        check("post_reset_wfid", 0, 64'(o_wfid[0]), 64'(0));

        // Round-robin skips a just-freed low slot; lowest-first reuses it.
        repeat (2) begin
            req[0] = 1'b1;
            req[1] = 1'b1;
            step();
        end
        set_rel(0, 0);
        set_rel(1, 0);
        step();
        req[0] = 1'b1;
        req[1] = 1'b1;
        step();
        check("rr_skip_freed", 1, 64'(o_wfid[1]), 64'(3));
        check("lowest_reuse", 0, 64'(o_wfid[0]), 64'(0));
        repeat (36) begin
            req[1] = 1'b1;
            step();
        end
        check("rr_top", 1, 64'(o_wfid[1]), 64'(39));
        req[1] = 1'b1;
        step();
        check("rr_wrap", 1, 64'(o_wfid[1]), 64'(0));

        // Random traffic on all pools.
        repeat (600) begin
            for (int c = 0; c < NCFG; c++) begin
                req[c] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1) set_rel(c, int'($urandom_range(0, CFG_N[c] + 1)));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
